compressed_pair_fetcher: RTL and testbench
==========================================

Name: compressed_pair_fetcher

Overview:
- Upstream feeder for decompress_handler.
- Walks a compressed stream stored in byte RAM, reads it two bytes at a time as (in1, in2) run pairs, and presents each pair to the handler together with the current destination byte/bit index.
- Waits for the handler to finish, adopts the handler's new indices, and repeats until the programmed pair count is exhausted.
- Owns the RAM read port only during its fetch states; the handler owns RAM in all other states.

Parameters:
- ADDR_W, 16, RAM byte-address width and source pointer width.
- CNT_W, 16, width of the pair counter.
- TIMEOUT, 1024, maximum cycles to wait for handlerDone before flagging an error.

Ports:
- clk  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a job; ignored unless in IDLE.
- srcBase  in  ADDR_W  byte address of the first compressed byte.
- pairCount  in  CNT_W  number of (in1, in2) pairs to process.
- dstByteStart  in  32  initial destination byte index.
- dstBitStart  in  3  initial destination bit index.
- ramAddress  out  ADDR_W  RAM read address.
- ramReadSignal  out  1  RAM read strobe.
- ramDataIn  in  8  RAM read data; valid on the cycle after the strobe.
- in1  out  8  first byte of the current pair, to the handler.
- in2  out  8  second byte of the current pair, to the handler.
- byteIndx  out  32  current destination byte index, to the handler.
- bitIndx  out  3  current destination bit index, to the handler.
- work  out  1  pair-valid strobe, to the handler.
- working  out  1  handler enable; high from ISSUE through WAIT_DONE.
- handlerDone  in  1  handler done level.
- newByteIndx  in  32  handler's updated byte index.
- newBitIndx  in  3  handler's updated bit index.
- busy  out  1  high in every state except IDLE.
- finished  out  1  one-cycle pulse at job end.
- error  out  1  sticky timeout flag; cleared by the next accepted start.

Behaviour:
- Reset, RST low, asynchronous: state IDLE; all outputs 0, including in1, in2, byteIndx, bitIndx and the internal pointer and counters. This applies mid-job as well: outputs are forced to 0 immediately, not at the next clock edge.
- Handler interface: the handler does not check in1/in2 for changes, so in1, in2, byteIndx and bitIndx must stay stable from ISSUE until leaving WAIT_DONE.
- IDLE:
  - On start, latch ptr=srcBase, cnt=pairCount, byteIndx=dstByteStart, bitIndx=dstBitStart, and clear error.
  - If pairCount==0, go to FIN.
  - Otherwise go to FETCH_A.
- FETCH_A: ramAddress=ptr, ramReadSignal=1. Next state: FETCH_B.
- FETCH_B:
  - Capture in1=ramDataIn.
  - Drive ramAddress=ptr+1 (mod 2^ADDR_W), ramReadSignal=1.
  - Next state: LATCH_B.
- LATCH_B:
  - Capture in2=ramDataIn; ramReadSignal=0.
  - If in1[6:0]+in2[6:0]==0 (zero-length pair), go to ADVANCE without invoking the handler; indices stay unchanged.
  - Otherwise go to ISSUE.
- ISSUE:
  - Assert work=1 and working=1.
  - Record prevDone=handlerDone.
  - Next state: WAIT_DONE.
- WAIT_DONE:
  - Hold work=1 and working=1.
  - Leave on a rising edge of handlerDone (current 1, registered previous 0). A stale done level left over from the prior pair is therefore ignored.
  - Timeout counter increments every cycle in this state. On reaching TIMEOUT: set error=1, deassert work and working, go to FIN. Remaining pairs are abandoned.
- ADVANCE:
  - work=0, working=0.
  - If the handler was invoked, byteIndx=newByteIndx and bitIndx=newBitIndx.
  - ptr=ptr+2 (wraps modulo 2^ADDR_W, e.g. 0xFFFF becomes 0x0001); cnt=cnt-1.
  - If cnt reaches 0, go to FIN; otherwise go to FETCH_A.
- FIN: finished=1 for exactly one cycle, then IDLE. busy falls on entry to IDLE.
- start while busy: ignored, with no effect on the latched job.
- Pair latency: 4 cycles from FETCH_A to ISSUE, plus handler time, plus 1 cycle of ADVANCE.
- RAM ownership: ramReadSignal=1 only in FETCH_A and FETCH_B; it is 0 whenever working=1.

Test Plan:
1. Single pair: srcBase=0x0010 with RAM[0x10]=0x83, RAM[0x11]=0x05, pairCount=1, dstByteStart=0, dstBitStart=7. Handler model returns done after 34 cycles with newByteIndx=1, newBitIndx=7.
   - Required: in1=0x83, in2=0x05 held stable through WAIT_DONE.
   - Required: read addresses 0x10 then 0x11.
   - Required: byteIndx=1 after ADVANCE; finished pulses once.
2. Three pairs starting at 0x20:
   - Required: reads at 0x20, 0x21, 0x22, 0x23, 0x24, 0x25.
   - Required: byteIndx and bitIndx chain through each handler update.
   - Required: exactly 3 work assertions, then finished.
3. Zero-length pair: RAM holds 0x80, 0x00 at srcBase, pairCount=1.
   - Required: work never asserts.
   - Required: indices unchanged.
   - Required: finished 5 cycles after start.
4. pairCount=0: start -> finished on the second cycle; no RAM read; busy high for one cycle.
5. Stale done and timeout:
   - handlerDone held at 1 before ISSUE -> the feeder waits for a fresh rising edge.
   - handlerDone held at 0 for TIMEOUT cycles -> error=1, then finished, then IDLE.
   - The next start clears error.
6. Address wrap and reset:
   - srcBase=0xFFFF, pairCount=2 -> reads at 0xFFFF, 0x0000, 0x0001, 0x0002.
   - RST asserted during WAIT_DONE -> all outputs 0 immediately; no finished pulse.

Source files
------------

// File: rtl/compressed_pair_fetcher.sv
// Feeder for decompress_handler: fetches (in1, in2) run pairs from byte RAM,
// hands each pair to the handler and chains the handler's updated indices.
module compressed_pair_fetcher #(
  parameter int ADDR_W  = 16,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] srcBase,
  input  logic [CNT_W-1:0]  pairCount,
  input  logic [31:0]       dstByteStart,
  input  logic [2:0]        dstBitStart,
  output logic [ADDR_W-1:0] ramAddress,
  output logic              ramReadSignal,
  input  logic [7:0]        ramDataIn,
  output logic [7:0]        in1,
  output logic [7:0]        in2,
  output logic [31:0]       byteIndx,
  output logic [2:0]        bitIndx,
  output logic              work,
  output logic              working,
  input  logic              handlerDone,
  input  logic [31:0]       newByteIndx,
  input  logic [2:0]        newBitIndx,
  output logic              busy,
  output logic              finished,
  output logic              error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH_A, FETCH_B, LATCH_B, ISSUE, WAIT_DONE, ADVANCE, FIN
  } state_t;

  state_t            state, nxt;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  cnt;
  logic [TW-1:0]     tcnt;
  logic              prev_done;
  logic              invoked;
  logic              done_edge;
  logic              zero_pair;
  logic              tmo;

  // Only a fresh rising edge counts; a level left over from the prior pair is stale.
  assign done_edge = handlerDone & ~prev_done;
  assign zero_pair = ({1'b0, in1[6:0]} + {1'b0, ramDataIn[6:0]}) == 8'd0;
  assign tmo       = (tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    nxt           = state;
    ramAddress    = '0;
    ramReadSignal = 1'b0;
    work          = 1'b0;
    working       = 1'b0;
    finished      = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE:    if (start) nxt = (pairCount == '0) ? FIN : FETCH_A;
      FETCH_A: begin
        ramAddress    = ptr;
        ramReadSignal = 1'b1;
        nxt           = FETCH_B;
      end
      FETCH_B: begin
        ramAddress    = ptr + ADDR_W'(1);
        ramReadSignal = 1'b1;
        nxt           = LATCH_B;
      end
      LATCH_B: nxt = zero_pair ? ADVANCE : ISSUE;
      ISSUE: begin
        work    = 1'b1;
        working = 1'b1;
        nxt     = WAIT_DONE;
      end
      WAIT_DONE: begin
        work    = 1'b1;
        working = 1'b1;
        if (done_edge) nxt = ADVANCE;
        else if (tmo)  nxt = FIN;
      end
      ADVANCE: nxt = (cnt == CNT_W'(1)) ? FIN : FETCH_A;
      FIN: begin
        finished = 1'b1;
        nxt      = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      tcnt      <= '0;
      prev_done <= 1'b0;
      invoked   <= 1'b0;
      in1       <= '0;
      in2       <= '0;
      byteIndx  <= '0;
      bitIndx   <= '0;
      error     <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (start) begin
          ptr      <= srcBase;
          cnt      <= pairCount;
          byteIndx <= dstByteStart;
          bitIndx  <= dstBitStart;
          error    <= 1'b0;
        end
        FETCH_B: in1 <= ramDataIn;
        LATCH_B: begin
          in2     <= ramDataIn;
          invoked <= ~zero_pair;
        end
        ISSUE: begin
          prev_done <= handlerDone;
          tcnt      <= '0;
        end
        WAIT_DONE: begin
          prev_done <= handlerDone;
          if (!done_edge) begin
            if (tmo) error <= 1'b1;
            else     tcnt  <= tcnt + TW'(1);
          end
        end
        ADVANCE: begin
          if (invoked) begin
            byteIndx <= newByteIndx;
            bitIndx  <= newBitIndx;
          end
          ptr <= ptr + ADDR_W'(2);
          cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_compressed_pair_fetcher.sv
// Bench for compressed_pair_fetcher: directed table, hand-written corner
// sequences and randomized jobs against a job-level reference model.
module tb_compressed_pair_fetcher;
  localparam int TMO = 1024;

  logic        clk = 1'b0;
  logic        RST;
  logic        start;
  logic [15:0] srcBase;
  logic [15:0] pairCount;
  logic [31:0] dstByteStart;
  logic [2:0]  dstBitStart;
  logic [15:0] ramAddress;
  logic        ramReadSignal;
  logic [7:0]  ramDataIn = 8'h00;
  logic [7:0]  in1, in2;
  logic [31:0] byteIndx;
  logic [2:0]  bitIndx;
  logic        work, working;
  logic        handlerDone;
  logic [31:0] newByteIndx;
  logic [2:0]  newBitIndx;
  logic        busy, finished, error;

  always #5 clk = ~clk;

  compressed_pair_fetcher #(.ADDR_W(16), .CNT_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .RST(RST), .start(start), .srcBase(srcBase), .pairCount(pairCount),
    .dstByteStart(dstByteStart), .dstBitStart(dstBitStart),
    .ramAddress(ramAddress), .ramReadSignal(ramReadSignal), .ramDataIn(ramDataIn),
    .in1(in1), .in2(in2), .byteIndx(byteIndx), .bitIndx(bitIndx),
    .work(work), .working(working), .handlerDone(handlerDone),
    .newByteIndx(newByteIndx), .newBitIndx(newBitIndx),
    .busy(busy), .finished(finished), .error(error)
  );

  // Byte RAM with one-cycle read latency
  logic [7:0] mem [0:65535];
  always @(posedge clk) if (ramReadSignal) ramDataIn <= mem[ramAddress];

  // Handler model: advances the bit position by in1[6:0]+in2[6:0], done after hlat cycles
  int   hlat = 1;
  int   hcnt;
  logic mdone;
  logic manual = 1'b0;
  logic man_done = 1'b0;
  logic [34:0] npos;
  assign npos        = {byteIndx, bitIndx} + 35'(in1[6:0]) + 35'(in2[6:0]);
  assign newByteIndx = npos[34:3];
  assign newBitIndx  = npos[2:0];
  assign handlerDone = manual ? man_done : mdone;

  always @(posedge clk or negedge RST) begin
    if (!RST || !working) begin
      hcnt  <= 0;
      mdone <= 1'b0;
    end else begin
      hcnt <= hcnt + 1;
      if (hcnt + 1 == hlat) mdone <= 1'b1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model results
  longint         m_byte, m_bit, m_works, m_cyc, m_err;
  logic [15:0]    m_reads[$];
  logic [15:0]    m_pairs[$];

  task automatic ref_job(input logic [15:0] src, input int cnt, input logic [31:0] byt,
                         input logic [2:0] bt, input int lat);
    longint pos = longint'(byt) * 8 + longint'(bt);
    int p = src;
    m_cyc = 1; m_works = 0; m_err = 0;
    m_reads.delete(); m_pairs.delete();
    for (int i = 0; i < cnt; i++) begin
      int a = mem[p];
      int b = mem[(p + 1) % 65536];
      int len = (a % 128) + (b % 128);
      m_reads.push_back(16'(p));
      m_reads.push_back(16'((p + 1) % 65536));
      if (len == 0) m_cyc += 4;
      else begin
        m_works++;
        m_pairs.push_back({8'(a), 8'(b)});
        if (lat > TMO) begin
          m_cyc += 4 + TMO;
          m_err = 1;
          break;
        end
        m_cyc += 5 + lat;
        pos += len;
      end
      p = (p + 2) % 65536;
    end
    m_cyc += 0;
    m_byte = (pos / 8) % 64'h1_0000_0000;
    m_bit  = pos % 8;
  endtask

  // Observations of one job
  logic [15:0] o_reads[$];
  logic [15:0] o_pairs[$];
  int o_works, o_fins, o_fin_n, o_stab, o_conf;
  longint o_err, o_busy_after;

  task automatic run_job(input logic [15:0] src, input int cnt, input logic [31:0] byt,
                         input logic [2:0] bt, input int lat);
    logic [50:0] snap = '0;
    logic        pw = 1'b0;
    int          n;
    o_reads.delete(); o_pairs.delete();
    o_works = 0; o_fins = 0; o_fin_n = 0; o_stab = 0; o_conf = 0;
    hlat = lat;
    @(negedge clk);
    srcBase = src; pairCount = 16'(cnt); dstByteStart = byt; dstBitStart = bt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    n = 1;
    while (o_fins == 0 && n < 3000) begin
      if (ramReadSignal) o_reads.push_back(ramAddress);
      if (ramReadSignal && working) o_conf++;
      if (work && !pw) begin
        o_works++;
        o_pairs.push_back({in1, in2});
        snap = {in1, in2, byteIndx, bitIndx};
      end else if (work && snap != {in1, in2, byteIndx, bitIndx}) o_stab++;
      pw = work;
      if (finished) begin o_fins++; o_fin_n = n; end
      else begin @(negedge clk); n++; end
    end
    if (o_fins == 0) chk("job_bound", 0, 1);
    @(negedge clk);
    o_err = error;
    o_busy_after = busy;
    if (finished) o_fins++;
    @(negedge clk);
    if (finished) o_fins++;
  endtask

  task automatic check_job(input string tag, input longint eb, input longint ebit,
                           input longint ew, input longint ecyc, input longint eerr);
    chk({tag, "_byte"}, byteIndx, eb);
    chk({tag, "_bit"}, bitIndx, ebit);
    chk({tag, "_works"}, o_works, ew);
    chk({tag, "_cycles"}, o_fin_n, ecyc);
    chk({tag, "_err"}, o_err, eerr);
    chk({tag, "_fins"}, o_fins, 1);
    chk({tag, "_idle"}, o_busy_after, 0);
    chk({tag, "_stable"}, o_stab, 0);
    chk({tag, "_ramconf"}, o_conf, 0);
    chk({tag, "_nreads"}, o_reads.size(), m_reads.size());
    for (int i = 0; i < o_reads.size() && i < m_reads.size(); i++)
      chk({tag, "_raddr"}, o_reads[i], m_reads[i]);
    chk({tag, "_npairs"}, o_pairs.size(), m_pairs.size());
    for (int i = 0; i < o_pairs.size() && i < m_pairs.size(); i++)
      chk({tag, "_pair"}, o_pairs[i], m_pairs[i]);
  endtask

  typedef struct {
    logic [15:0] src;
    int          cnt;
    logic [31:0] byt;
    logic [2:0]  bt;
    int          lat;
    logic [7:0]  d [6];
    logic [31:0] eb;
    logic [2:0]  ebit;
    int          ew;
    int          ecyc;
    int          eerr;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [15:0] src, input int cnt, input logic [31:0] byt,
                         input logic [2:0] bt, input int lat,
                         input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [7:0] d3, input logic [7:0] d4, input logic [7:0] d5,
                         input logic [31:0] eb, input logic [2:0] ebit, input int ew,
                         input int ecyc, input int eerr);
    vec_t v;
    v.src = src; v.cnt = cnt; v.byt = byt; v.bt = bt; v.lat = lat;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3; v.d[4] = d4; v.d[5] = d5;
    v.eb = eb; v.ebit = ebit; v.ew = ew; v.ecyc = ecyc; v.eerr = eerr;
    vecs.push_back(v);
  endtask

  initial begin
    int n;
    int seen;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    RST = 1'b0; start = 1'b0; srcBase = '0; pairCount = '0;
    dstByteStart = '0; dstBitStart = '0;

    add_vec(16'h0010, 1, 0,   7, 34,   8'h83, 8'h05, 0, 0, 0, 0,          1, 7, 1, 40,   0);
    add_vec(16'h0020, 3, 5,   2, 3,    8'h02, 8'h03, 8'h10, 8'h00, 8'h01, 8'h7F, 23, 7, 3, 25, 0);
    add_vec(16'h0030, 1, 9,   4, 5,    8'h80, 8'h00, 0, 0, 0, 0,          9, 4, 0, 5,    0);
    add_vec(16'h0040, 0, 77,  3, 5,    8'h11, 8'h22, 0, 0, 0, 0,          77, 3, 0, 1,   0);
    add_vec(16'hFFFF, 2, 0,   0, 2,    8'h01, 8'h02, 8'h00, 8'h04, 0, 0,  0, 7, 2, 15,   0);
    add_vec(16'h0050, 3, 100, 0, 2000, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 100, 0, 1, 5 + TMO, 1);
    add_vec(16'h0060, 1, 0,   0, 1,    8'h7F, 8'h7F, 0, 0, 0, 0,          31, 6, 1, 7,   0);

    #12;
    chk("rst_outs_a", {ramAddress, ramReadSignal, work, working, busy, finished, error}, 0);
    chk("rst_outs_b", {in1, in2, byteIndx, bitIndx}, 0);
    RST = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[k]) begin
      for (int i = 0; i < 6; i++) mem[(int'(vecs[k].src) + i) % 65536] = vecs[k].d[i];
      ref_job(vecs[k].src, vecs[k].cnt, vecs[k].byt, vecs[k].bt, vecs[k].lat);
      run_job(vecs[k].src, vecs[k].cnt, vecs[k].byt, vecs[k].bt, vecs[k].lat);
      check_job($sformatf("vec%0d", k), vecs[k].eb, vecs[k].ebit, vecs[k].ew, vecs[k].ecyc,
                vecs[k].eerr);
    end

    // Stale done: level already high at ISSUE must not end the wait
    mem[16'h0070] = 8'h05; mem[16'h0071] = 8'h06;
    manual = 1'b1; man_done = 1'b1;
    @(negedge clk);
    srcBase = 16'h0070; pairCount = 16'd1; dstByteStart = 0; dstBitStart = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!working && n < 20) begin @(negedge clk); n++; end
    chk("stale_reach_wait", working, 1);
    repeat (6) @(negedge clk);
    chk("stale_ignored", working, 1);
    man_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("stale_low_wait", working, 1);
    man_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stale_released", working, 0);
    n = 0; seen = 0;
    while (seen == 0 && n < 10) begin
      if (finished) seen = 1; else begin @(negedge clk); n++; end
    end
    chk("stale_fin", seen, 1);
    chk("stale_byte", byteIndx, 1);
    chk("stale_bit", bitIndx, 3);
    manual = 1'b0; man_done = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized jobs
    for (int j = 0; j < 16; j++) begin
      logic [15:0] src = 16'($urandom);
      int cnt = int'($urandom_range(0, 4));
      int lat = int'($urandom_range(1, 20));
      logic [31:0] byt = $urandom;
      logic [2:0]  bt = 3'($urandom);
      for (int i = 0; i < 2 * cnt; i += 2) begin
        if ($urandom_range(0, 3) == 0) begin
          mem[(int'(src) + i) % 65536]     = 8'($urandom) & 8'h80;
          mem[(int'(src) + i + 1) % 65536] = 8'($urandom) & 8'h80;
        end else begin
          mem[(int'(src) + i) % 65536]     = 8'($urandom);
          mem[(int'(src) + i + 1) % 65536] = 8'($urandom);
        end
      end
      ref_job(src, cnt, byt, bt, lat);
      run_job(src, cnt, byt, bt, lat);
      check_job($sformatf("rnd%0d", j), m_byte, m_bit, m_works, m_cyc, m_err);
    end

    // Reset in WAIT_DONE: outputs drop before the next clock edge, no finished pulse
    mem[16'h0080] = 8'h11; mem[16'h0081] = 8'h22;
    hlat = 500;
    @(negedge clk);
    srcBase = 16'h0080; pairCount = 16'd2; dstByteStart = 32'h1234; dstBitStart = 3'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!working && n < 20) begin @(negedge clk); n++; end
    chk("rst_reach_wait", working, 1);
    repeat (3) @(negedge clk);
    #2 RST = 1'b0;
    #1;
    chk("rst_mid_a", {ramAddress, ramReadSignal, work, working, busy, finished, error}, 0);
    chk("rst_mid_b", {in1, in2, byteIndx, bitIndx}, 0);
    seen = 0;
    repeat (4) begin @(negedge clk); if (finished) seen++; end
    RST = 1'b1;
    repeat (4) begin @(negedge clk); if (finished || busy) seen++; end
    chk("rst_no_fin", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
